// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I(+M) decode-stage control path.
// Contents: opcode and funct7 constants, control-field encodings, the
// packed control word carried from D into the ID/EX control register,
// and a small constructor used by the decoder.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I       = 3'b000,
    IMM_S       = 3'b001,
    IMM_B       = 3'b010,
    IMM_J       = 3'b011,
    IMM_U_AUIPC = 3'b100,
    IMM_U_LUI   = 3'b101
  } imm_src_e;

  typedef struct packed {
    logic        reg_write;
    imm_src_e    imm_src;
    logic        alu_src;
    logic        mem_write;
    result_src_e result_src;
    alu_op_e     alu_op;
    logic        jump;
    logic        jalr;
    logic        branch;
    logic        mul_div;
    logic [2:0]  mul_div_op;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NONE = '0;

  // Builds a base-ISA control word; the M fields start cleared.
  function automatic ctrl_word_t make_ctrl(
    input logic        reg_write,
    input imm_src_e    imm_src,
    input logic        alu_src,
    input logic        mem_write,
    input result_src_e result_src,
    input alu_op_e     alu_op,
    input logic        jump,
    input logic        jalr,
    input logic        branch
  );
    ctrl_word_t w;
    w            = CTRL_NONE;
    w.reg_write  = reg_write;
    w.imm_src    = imm_src;
    w.alu_src    = alu_src;
    w.mem_write  = mem_write;
    w.result_src = result_src;
    w.alu_op     = alu_op;
    w.jump       = jump;
    w.jalr       = jalr;
    w.branch     = branch;
    return w;
  endfunction

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// D-to-E control bundle of the decode stage.
// D side: InstrD, ValidD, FlushE. E side: registered controls, IllegalE,
// ValidE, plus the MUL/DIV hold signals StallMD and MdBusy.
// master = pipeline/driver side, slave = decode_ctrl_stage.
interface decode_ctrl_stage_if;
  logic [31:0] InstrD;
  logic        ValidD;
  logic        FlushE;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        BranchE;
  logic        JumpE;
  logic        JalrE;
  logic        ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ImmSrcE;
  logic [1:0]  ALUOpE;
  logic        MulDivE;
  logic [2:0]  MulDivOpE;
  logic        IllegalE;
  logic        ValidE;
  logic        StallMD;
  logic        MdBusy;

  modport master (
    output InstrD, ValidD, FlushE,
    input  RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE,
    input  ResultSrcE, ImmSrcE, ALUOpE, MulDivE, MulDivOpE,
    input  IllegalE, ValidE, StallMD, MdBusy
  );

  modport slave (
    input  InstrD, ValidD, FlushE,
    output RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE,
    output ResultSrcE, ImmSrcE, ALUOpE, MulDivE, MulDivOpE,
    output IllegalE, ValidE, StallMD, MdBusy
  );
endinterface

// File: rtl/rv_ctrl_decode.sv
// Combinational RV32I(+M) opcode decoder.
// Ports: instr_i (instruction in D), valid_i (not a bubble),
//        ctrl_o (control word, all zero for bubbles and illegal encodings),
//        illegal_o (valid instruction with an illegal encoding).
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
#(
  parameter int ENABLE_M = 1
) (
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  output ctrl_word_t  ctrl_o,
  output logic        illegal_o
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  ctrl_word_t word;
  logic       legal;
  logic       unused_fields;

  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  // Register and immediate fields are decoded elsewhere in the pipeline.
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  // NOTE: every variable gets a default at the top of the block so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    word  = CTRL_NONE;
    legal = 1'b1;
    case (op)
      OP_LOAD: begin
        word  = make_ctrl(1'b1, IMM_I, 1'b1, 1'b0, RES_MEM, ALU_ADD, 1'b0, 1'b0, 1'b0);
        legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OP_STORE: begin
        word  = make_ctrl(1'b0, IMM_S, 1'b1, 1'b1, RES_ALU, ALU_ADD, 1'b0, 1'b0, 1'b0);
        legal = f3 inside {3'b000, 3'b001, 3'b010};
      end
      OP_REG: begin
        word = make_ctrl(1'b1, IMM_I, 1'b0, 1'b0, RES_ALU, ALU_FUNCT, 1'b0, 1'b0, 1'b0);
        if (ENABLE_M != 0 && f7 == F7_MULDIV) begin
          word.mul_div    = 1'b1;
          word.mul_div_op = f3;
        end else begin
          legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        end
      end
      OP_BRANCH: begin
        word  = make_ctrl(1'b0, IMM_B, 1'b0, 1'b0, RES_ALU, ALU_SUB, 1'b0, 1'b0, 1'b1);
        legal = !(f3 inside {3'b010, 3'b011});
      end
      OP_IMM:   word = make_ctrl(1'b1, IMM_I, 1'b1, 1'b0, RES_ALU, ALU_FUNCT, 1'b0, 1'b0, 1'b0);
      OP_AUIPC: word = make_ctrl(1'b1, IMM_U_AUIPC, 1'b0, 1'b0, RES_IMM, ALU_ADD, 1'b0, 1'b0, 1'b0);
      OP_LUI:   word = make_ctrl(1'b1, IMM_U_LUI, 1'b0, 1'b0, RES_IMM, ALU_ADD, 1'b0, 1'b0, 1'b0);
      OP_JALR: begin
        word  = make_ctrl(1'b1, IMM_I, 1'b1, 1'b0, RES_PC4, ALU_FUNCT, 1'b1, 1'b1, 1'b0);
        legal = (f3 == 3'b000);
      end
      OP_JAL:   word = make_ctrl(1'b1, IMM_J, 1'b0, 1'b0, RES_PC4, ALU_ADD, 1'b1, 1'b0, 1'b0);
      default:  legal = 1'b0;
    endcase

    // Bubbles and illegal encodings both leave E with an inert word.
    ctrl_o    = (valid_i && legal) ? word : CTRL_NONE;
    illegal_o = valid_i && !legal;
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode-stage control unit: decodes InstrD, holds the ID/EX
// control register, and keeps a multi-cycle MUL/DIV in E by stalling F/D.
// Ports: clk, reset (synchronous, active-high), bus (slave side of
//        decode_ctrl_stage_if: D inputs, registered E controls,
//        StallMD combinational hold request, MdBusy FSM status).
module decode_ctrl_stage
  import rv_ctrl_pkg::*;
#(
  parameter int ENABLE_M   = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  decode_ctrl_stage_if.slave   bus
);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  localparam logic [4:0] MUL_L = 5'(MUL_CYCLES);
  localparam logic [4:0] DIV_L = 5'(DIV_CYCLES);

  ctrl_word_t ctrl_d, ctrl_q;
  logic       illegal_d, illegal_q;
  logic       valid_q;
  md_state_e  state_d, state_q;
  logic [3:0] cnt_d, cnt_q;
  logic [4:0] lat;
  logic       launch;
  logic       stall;

  rv_ctrl_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .instr_i   (bus.InstrD),
    .valid_i   (bus.ValidD),
    .ctrl_o    (ctrl_d),
    .illegal_o (illegal_d)
  );

  // funct3[2] separates the divide group from the multiply group.
  assign lat    = ctrl_q.mul_div_op[2] ? DIV_L : MUL_L;
  assign launch = valid_q && ctrl_q.mul_div && (lat > 5'd1);

  // The launch cycle counts as the first of L, and the cnt==0 BUSY cycle
  // as the last, so cnt starts at L-2.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (launch) begin
          stall   = 1'b1;
          state_d = MD_BUSY;
          cnt_d   = 4'(lat - 5'd2);
        end
      end
      MD_BUSY: begin
        stall = (cnt_q != 4'd0);
        if (cnt_q == 4'd0) state_d = MD_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = MD_IDLE;
    endcase
    // A flush aborts the in-flight op and releases F/D immediately.
    if (bus.FlushE) begin
      state_d = MD_IDLE;
      cnt_d   = 4'd0;
      stall   = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the control register is reset because a random ValidE or
  // RegWriteE out of reset would corrupt architectural state.
  always_ff @(posedge clk) begin
    if (reset || bus.FlushE) begin
      ctrl_q    <= CTRL_NONE;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else if (!stall) begin
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      valid_q   <= bus.ValidD;
    end
  end

  assign bus.RegWriteE  = ctrl_q.reg_write;
  assign bus.MemWriteE  = ctrl_q.mem_write;
  assign bus.BranchE    = ctrl_q.branch;
  assign bus.JumpE      = ctrl_q.jump;
  assign bus.JalrE      = ctrl_q.jalr;
  assign bus.ALUSrcE    = ctrl_q.alu_src;
  assign bus.ResultSrcE = ctrl_q.result_src;
  assign bus.ImmSrcE    = ctrl_q.imm_src;
  assign bus.ALUOpE     = ctrl_q.alu_op;
  assign bus.MulDivE    = ctrl_q.mul_div;
  assign bus.MulDivOpE  = ctrl_q.mul_div_op;
  assign bus.IllegalE   = illegal_q;
  assign bus.ValidE     = valid_q;
  assign bus.StallMD    = stall;
  assign bus.MdBusy     = (state_q == MD_BUSY);

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage with three parameterisations:
// u_a defaults (M on, MUL=2, DIV=8), u_b M disabled, u_c MUL=1.
module tb_decode_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        valid_d;
  logic        flush;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  decode_ctrl_stage_if bus_a ();
  decode_ctrl_stage_if bus_b ();
  decode_ctrl_stage_if bus_c ();

  assign bus_a.InstrD = instr;  assign bus_a.ValidD = valid_d;  assign bus_a.FlushE = flush;
  assign bus_b.InstrD = instr;  assign bus_b.ValidD = valid_d;  assign bus_b.FlushE = flush;
  assign bus_c.InstrD = instr;  assign bus_c.ValidD = valid_d;  assign bus_c.FlushE = flush;

  decode_ctrl_stage #(.ENABLE_M(1), .MUL_CYCLES(2), .DIV_CYCLES(8)) u_a (
    .clk(clk), .reset(rst), .bus(bus_a));
  decode_ctrl_stage #(.ENABLE_M(0), .MUL_CYCLES(1), .DIV_CYCLES(8)) u_b (
    .clk(clk), .reset(rst), .bus(bus_b));
  decode_ctrl_stage #(.ENABLE_M(1), .MUL_CYCLES(1), .DIV_CYCLES(8)) u_c (
    .clk(clk), .reset(rst), .bus(bus_c));

  localparam logic [31:0] I_DIV  = 32'h023140B3;
  localparam logic [31:0] I_MUL  = 32'h023100B3;
  localparam logic [31:0] I_ADDI = 32'h00100093;
  localparam logic [31:0] I_JAL  = 32'h008000EF;

  // {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, ALUOp, Jump, Jalr, Branch, Illegal}
  localparam logic [13:0] W_LW   = 14'b1_000_1_0_01_00_0_0_0_0;
  localparam logic [13:0] W_SW   = 14'b0_001_1_1_00_00_0_0_0_0;
  localparam logic [13:0] W_R    = 14'b1_000_0_0_00_10_0_0_0_0;
  localparam logic [13:0] W_BR   = 14'b0_010_0_0_00_01_0_0_1_0;
  localparam logic [13:0] W_IALU = 14'b1_000_1_0_00_10_0_0_0_0;
  localparam logic [13:0] W_AUI  = 14'b1_100_0_0_11_00_0_0_0_0;
  localparam logic [13:0] W_LUI  = 14'b1_101_0_0_11_00_0_0_0_0;
  localparam logic [13:0] W_JALR = 14'b1_000_1_0_10_10_1_1_0_0;
  localparam logic [13:0] W_JAL  = 14'b1_011_0_0_10_00_1_0_0_0;
  localparam logic [13:0] W_ILL  = 14'b0_000_0_0_00_00_0_0_0_1;

  localparam int NVEC = 16;
  localparam logic [45:0] VECS [NVEC] = '{
    {32'h00002083, W_LW},   // lw x1,0(x0)
    {32'h00003083, W_ILL},  // load funct3 011
    {32'h00112023, W_SW},   // sw
    {32'h00114023, W_ILL},  // store funct3 100
    {32'h003100B3, W_R},    // add
    {32'h403100B3, W_R},    // sub
    {32'h043100B3, W_ILL},  // R-type funct7 0000010
    {32'h00208063, W_BR},   // beq
    {32'h0020A063, W_ILL},  // branch funct3 010
    {I_ADDI,       W_IALU}, // addi
    {32'h00001097, W_AUI},  // auipc
    {32'h000010B7, W_LUI},  // lui
    {32'h000080E7, W_JALR}, // jalr
    {32'h000090E7, W_ILL},  // jalr funct3 001
    {I_JAL,        W_JAL},  // jal
    {32'h0000007F, W_ILL}   // unknown opcode
  };

  function automatic logic [13:0] word_a();
    return {bus_a.RegWriteE, bus_a.ImmSrcE, bus_a.ALUSrcE, bus_a.MemWriteE,
            bus_a.ResultSrcE, bus_a.ALUOpE, bus_a.JumpE, bus_a.JalrE,
            bus_a.BranchE, bus_a.IllegalE};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic v);
    instr   = i;
    valid_d = v;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(32'h0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    check("rst_word",   32'(word_a()),      32'h0);
    check("rst_valid",  32'(bus_a.ValidE),  32'h0);
    check("rst_muldiv", 32'(bus_a.MulDivE), 32'h0);
    check("rst_stall",  32'(bus_a.StallMD), 32'h0);
    check("rst_busy",   32'(bus_a.MdBusy),  32'h0);

    // Decode table: each word appears in E one edge after capture.
    for (int i = 0; i < NVEC; i++) begin
      drive(VECS[i][45:14], 1'b1);
      tick();
      check($sformatf("vec%0d_word", i), 32'(word_a()), 32'(VECS[i][13:0]));
      check($sformatf("vec%0d_valid", i), 32'(bus_a.ValidE), 32'h1);
      check($sformatf("vec%0d_stall", i), 32'(bus_a.StallMD), 32'h0);
    end

    // Bubble carrying an illegal opcode is not flagged.
    drive(32'h0000007F, 1'b0);
    tick();
    check("bubble_illegal", 32'(bus_a.IllegalE), 32'h0);
    check("bubble_valid",   32'(bus_a.ValidE),   32'h0);
    check("bubble_word",    32'(word_a()),       32'h0);

    // DIV, L=8: stall on cycles 0..6, E held for 8 cycles, addi on the 9th.
    drive(I_DIV, 1'b1);
    tick();
    drive(I_ADDI, 1'b1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("div_stall_c%0d", k), 32'(bus_a.StallMD), 32'(k < 7));
      check($sformatf("div_busy_c%0d", k),  32'(bus_a.MdBusy),  32'(k >= 1));
      check($sformatf("div_valid_c%0d", k), 32'(bus_a.ValidE),  32'h1);
      check($sformatf("div_md_c%0d", k),    32'(bus_a.MulDivE), 32'h1);
      check($sformatf("div_op_c%0d", k),    32'(bus_a.MulDivOpE), 32'h4);
      tick();
    end
    check("div_next_word",  32'(word_a()),       32'(W_IALU));
    check("div_next_md",    32'(bus_a.MulDivE),  32'h0);
    check("div_next_busy",  32'(bus_a.MdBusy),   32'h0);
    check("div_next_stall", 32'(bus_a.StallMD),  32'h0);

    // DIV flushed on its 3rd BUSY cycle.
    drive(I_DIV, 1'b1);
    tick();
    drive(I_ADDI, 1'b1);
    tick(); tick(); tick();
    check("fl_busy_before", 32'(bus_a.MdBusy),  32'h1);
    flush = 1'b1;
    #1;
    check("fl_stall_drop",  32'(bus_a.StallMD), 32'h0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_valid",  32'(bus_a.ValidE),  32'h0);
    check("fl_busy",   32'(bus_a.MdBusy),  32'h0);
    check("fl_md",     32'(bus_a.MulDivE), 32'h0);
    check("fl_stall",  32'(bus_a.StallMD), 32'h0);
    tick();
    check("fl_resume_valid", 32'(bus_a.ValidE), 32'h1);
    check("fl_resume_word",  32'(word_a()),     32'(W_IALU));

    // MUL: L=2 on u_a, L=1 on u_c, illegal on u_b.
    drive(I_MUL, 1'b1);
    tick();
    drive(I_ADDI, 1'b1);
    #1;
    check("mul2_stall",  32'(bus_a.StallMD), 32'h1);
    check("mul1_stall",  32'(bus_c.StallMD), 32'h0);
    check("mul1_busy",   32'(bus_c.MdBusy),  32'h0);
    check("mul1_md",     32'(bus_c.MulDivE), 32'h1);
    check("mul1_op",     32'(bus_c.MulDivOpE), 32'h0);
    check("nom_illegal", 32'(bus_b.IllegalE), 32'h1);
    check("nom_md",      32'(bus_b.MulDivE),  32'h0);
    check("nom_rw",      32'(bus_b.RegWriteE), 32'h0);
    check("nom_stall",   32'(bus_b.StallMD),  32'h0);
    tick();
    check("mul2_c1_stall", 32'(bus_a.StallMD), 32'h0);
    check("mul2_c1_busy",  32'(bus_a.MdBusy),  32'h1);
    check("mul2_c1_md",    32'(bus_a.MulDivE), 32'h1);
    check("mul1_next_md",  32'(bus_c.MulDivE), 32'h0);
    tick();
    check("mul2_c2_md",    32'(bus_a.MulDivE), 32'h0);
    check("mul2_c2_busy",  32'(bus_a.MdBusy),  32'h0);

    // Reset in the middle of a DIV, then jal decodes normally.
    drive(I_DIV, 1'b1);
    tick();
    drive(I_JAL, 1'b1);
    tick(); tick();
    check("rb_busy_before", 32'(bus_a.MdBusy), 32'h1);
    rst = 1'b1;
    tick();
    check("rb_word",  32'(word_a()),      32'h0);
    check("rb_valid", 32'(bus_a.ValidE),  32'h0);
    check("rb_md",    32'(bus_a.MulDivE), 32'h0);
    check("rb_stall", 32'(bus_a.StallMD), 32'h0);
    check("rb_busy",  32'(bus_a.MdBusy),  32'h0);
    rst = 1'b0;
    tick();
    check("rb_jal_word",  32'(word_a()),        32'(W_JAL));
    check("rb_jal_jump",  32'(bus_a.JumpE),     32'h1);
    check("rb_jal_res",   32'(bus_a.ResultSrcE), 32'h2);
    check("rb_jal_imm",   32'(bus_a.ImmSrcE),   32'h3);
    check("rb_jal_valid", 32'(bus_a.ValidE),    32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered decode-stage control unit for the pipelined RV32I core, with optional M extension. It decodes the instruction in D into a control word, registers it into the ID/EX control register, and flags illegal encodings. It also holds the E stage for multi-cycle MUL/DIV operations, asserting a stall back to F/D. It replaces the purely combinational opcode decoder plus the separate ID/EX control flops.

## Interface
Parameters:
- `ENABLE_M`, default 1: decode the M extension; when 0, M encodings are illegal.
- `MUL_CYCLES`, default 2: E-stage occupancy of MUL/MULH/MULHSU/MULHU, range 1..16.
- `DIV_CYCLES`, default 8: E-stage occupancy of DIV/DIVU/REM/REMU, range 1..16.

Ports:
- `clk` input, 1 bit: clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `InstrD` input, 32 bits: instruction in D. op=[6:0], funct3=[14:12], funct7=[31:25].
- `ValidD` input, 1 bit: `InstrD` is a real instruction, not a bubble.
- `FlushE` input, 1 bit: hazard or mispredict bubble insert into E.
- `RegWriteE`, `MemWriteE`, `BranchE`, `JumpE`, `JalrE`, `ALUSrcE` outputs, 1 bit each: registered controls.
- `ResultSrcE` output, 2 bits; `ImmSrcE` output, 3 bits; `ALUOpE` output, 2 bits: registered controls.
- `MulDivE` output, 1 bit; `MulDivOpE` output, 3 bits (funct3 of the M op): registered.
- `IllegalE` output, 1 bit: the instruction in E is an illegal encoding.
- `ValidE` output, 1 bit: E holds a real instruction.
- `StallMD` output, 1 bit: combinational; hold F, D and the E control register.
- `MdBusy` output, 1 bit: FSM is in BUSY.

## Operation
Control word fields: RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, ALUOp, Jump, Jalr, Branch. There are no don't-cares; every unspecified bit is 0.
- lw 0000011: 1,000,1,0,01,00,0,0,0. Legal funct3 values: 000, 001, 010, 100, 101.
- sw 0100011: 0,001,1,1,00,00,0,0,0. Legal funct3 values: 000, 001, 010.
- R-type 0110011 with funct7 of 0000000 or 0100000: 1,000,0,0,00,10,0,0,0.
- M-type 0110011 with funct7 0000001 and `ENABLE_M`=1: same as R-type, plus MulDiv=1 and MulDivOp=funct3.
- branch 1100011: 0,010,0,0,00,01,0,0,1. funct3 010 and 011 are illegal.
- I-ALU 0010011: 1,000,1,0,00,10,0,0,0.
- auipc 0010111: 1,100,0,0,11,00,0,0,0. lui 0110111: 1,101,0,0,11,00,0,0,0.
- jalr 1100111: 1,000,1,0,10,10,1,1,0. funct3 must be 000.
- jal 1101111: 1,011,0,0,10,00,1,0,0.
- Any other op, funct7 or funct3 is illegal. The control word becomes all zero, and Illegal=1 only when `ValidD`=1.
- When `ValidD`=0, the control word is all zero and Illegal=0.

State machine, states IDLE and BUSY, with a 4-bit down-counter `cnt`:
- IDLE: if `ValidE` & `MulDivE` & L>1, where L is `MUL_CYCLES` when `MulDivOpE`[2]=0 and `DIV_CYCLES` otherwise: load `cnt`=L-2 and go to BUSY.
- BUSY: `cnt` decrements each cycle. When `cnt`=0, go to IDLE.
- `StallMD` = (IDLE & launch condition) | (BUSY & `cnt`≠0).
- A held instruction therefore occupies E for exactly L cycles. L=1 never stalls.

E register update, in priority order:
1. `reset`: clear.
2. `FlushE`: load bubble, and force the FSM to IDLE. This aborts an in-flight MUL/DIV.
3. `StallMD`: hold.
4. Otherwise: load the decoded word, with `ValidE`=`ValidD`.

## Timing
- Decode is combinational from `InstrD`. Controls appear in E one cycle after capture.
- Reset value: all E outputs 0, `ValidE`=0, `IllegalE`=0, FSM in IDLE, `cnt`=0, `StallMD`=0, `MdBusy`=0.
- Reset or flush asserted mid-BUSY takes effect at that edge. `StallMD` drops in the same cycle that `FlushE`=1 is observed.
- Back-to-back M ops: the second op captures on the edge where `StallMD` falls, then launches its own hold.
- Illegal instructions flow through like bubbles (no RegWrite, no MemWrite) and never stall.

## Structure
- Shared package `rv_ctrl_pkg` holds:
  - opcode localparams;
  - the control-word packed struct;
  - ALUOp, ResultSrc and ImmSrc encodings;
  - the M funct7 constant.
- The combinational sub-module `rv_ctrl_decode` (InstrD, ValidD → control word, Illegal) is instantiated once. The FSM, counter and E register live in the top module.

## Test plan
- Reset, then lw x1 (0x00002083, ValidD=1) → next cycle RegWriteE=1, ResultSrcE=01, ALUSrcE=1, IllegalE=0, StallMD=0.
- DIV (funct7 0000001, funct3 100) with DIV_CYCLES=8 → StallMD high for 7 cycles, ValidE/MulDivE held for 8, next instruction enters on cycle 9.
- Same DIV with FlushE on the 3rd BUSY cycle → StallMD=0 that cycle, then ValidE=0 and MdBusy=0.
- op 1111111 with ValidD=1 → IllegalE=1, RegWriteE=0, MemWriteE=0. With ValidD=0 → IllegalE=0.
- MUL with MUL_CYCLES=1 → no stall; ENABLE_M=0 with MUL → IllegalE=1, MulDivE=0.
- Reset asserted mid-BUSY → next cycle all outputs 0, FSM IDLE; a subsequent jal decodes normally (JumpE=1, ResultSrcE=10, ImmSrcE=011).
